// File: rtl/stopwatch_lap.sv
// rtl/stopwatch_lap.sv - prescaled toggle-start stopwatch with wrap/saturate overflow and lap FIFO
module stopwatch_lap #(
    parameter int WIDTH    = 16,
    parameter int PRESCALE = 1000,
    parameter int LAPS     = 4,
    parameter int SATURATE = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       toggle,
    input  logic                       clear,
    input  logic                       lap,
    input  logic                       lap_rd,
    output logic [WIDTH-1:0]           timer,
    output logic                       running,
    output logic                       overflow,
    output logic [WIDTH-1:0]           lap_data,
    output logic                       lap_valid,
    output logic [$clog2(LAPS+1)-1:0]  lap_count,
    output logic                       lap_drop
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int AW = (LAPS > 1) ? $clog2(LAPS) : 1;
    localparam int CW = $clog2(LAPS + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [AW-1:0] PTR_LAST = AW'(LAPS - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(LAPS);

    logic             running_q, running_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [WIDTH-1:0] timer_q, timer_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] mem_q [LAPS];
    logic [WIDTH-1:0] mem_d [LAPS];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             drop_q, drop_d;

    logic tick, full, empty, do_push, do_pop;

    // Pointers wrap at LAPS rather than at a power of two.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        tick    = running_q && (presc_q == PRE_LAST);
        full    = (count_q == FULL_CNT);
        empty   = (count_q == '0);
        do_pop  = lap_rd && !empty && !clear;
        do_push = lap && (!full || lap_rd) && !clear;
        drop_d  = lap && full && !lap_rd && !clear;

        running_d  = running_q ^ toggle;
        presc_d    = presc_q;
        timer_d    = timer_q;
        overflow_d = overflow_q;
        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        if (clear) begin
            presc_d    = '0;
            timer_d    = '0;
            overflow_d = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            // The prescaler freezes while stopped so a pause keeps the partial period.
            if (running_q) begin
                presc_d = tick ? '0 : presc_q + 1'b1;
            end
            if (tick) begin
                if (&timer_q) begin
                    overflow_d = 1'b1;
                    timer_d    = (SATURATE != 0) ? timer_q : '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            if (do_push) begin
                mem_d[wr_ptr_q] = timer_q;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            running_q  <= 1'b0;
            presc_q    <= '0;
            timer_q    <= '0;
            overflow_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            drop_q     <= 1'b0;
            for (int i = 0; i < LAPS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            running_q  <= running_d;
            presc_q    <= presc_d;
            timer_q    <= timer_d;
            overflow_q <= overflow_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            drop_q     <= drop_d;
            mem_q      <= mem_d;
        end
    end

    always_comb begin
        timer     = timer_q;
        running   = running_q;
        overflow  = overflow_q;
        lap_valid = (count_q != '0);
        lap_count = count_q;
        lap_drop  = drop_q;
        lap_data  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    end

endmodule

// File: tb/tb_stopwatch_lap.sv
// tb/tb_stopwatch_lap.sv - self-checking bench for stopwatch_lap across four parameter sets
module tb_stopwatch_lap;

    localparam int NI = 4;
    localparam int MW [NI] = '{8, 4, 4, 16};
    localparam int MP [NI] = '{3, 1, 1, 1};
    localparam int MS [NI] = '{0, 0, 1, 0};
    localparam int L = 4;

    logic clk = 1'b0;
    logic reset, toggle, clear, lap, lap_rd;

    logic [15:0] o_tmr [NI];
    logic [15:0] o_ld  [NI];
    logic        o_run [NI];
    logic        o_ovf [NI];
    logic        o_val [NI];
    logic        o_drop[NI];
    logic [2:0]  o_cnt [NI];

    int checks = 0;
    int failures = 0;

    int m_run [NI];
    int m_pre [NI];
    int m_tmr [NI];
    int m_ovf [NI];
    int m_drop[NI];
    int m_cnt [NI];
    int m_fifo[NI][L];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [MW[g]-1:0] t;
        logic [MW[g]-1:0] d;
        stopwatch_lap #(.WIDTH(MW[g]), .PRESCALE(MP[g]), .LAPS(L), .SATURATE(MS[g])) u_dut (
            .clk(clk), .reset(reset), .toggle(toggle), .clear(clear), .lap(lap), .lap_rd(lap_rd),
            .timer(t), .running(o_run[g]), .overflow(o_ovf[g]), .lap_data(d),
            .lap_valid(o_val[g]), .lap_count(o_cnt[g]), .lap_drop(o_drop[g])
        );
        assign o_tmr[g] = 16'(t);
        assign o_ld[g]  = 16'(d);
    end

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_run[i] = 0; m_pre[i] = 0; m_tmr[i] = 0; m_ovf[i] = 0; m_drop[i] = 0; m_cnt[i] = 0;
            for (int k = 0; k < L; k++) m_fifo[i][k] = 0;
        end
    endtask

    // Elapsed running cycles modulo PRESCALE decide ticks; the lap queue is a shifting array.
    task automatic model_step(input bit tg, input bit cl, input bit lp, input bit rd);
        int maxv, old_t;
        bit tick;
        for (int i = 0; i < NI; i++) begin
            maxv  = (1 << MW[i]) - 1;
            old_t = m_tmr[i];
            tick  = (m_run[i] != 0) && (m_pre[i] == MP[i] - 1);
            m_drop[i] = 0;
            if (cl) begin
                m_tmr[i] = 0; m_pre[i] = 0; m_ovf[i] = 0; m_cnt[i] = 0;
            end else begin
                if (m_run[i] != 0) m_pre[i] = (m_pre[i] + 1) % MP[i];
                if (tick) begin
                    if (old_t == maxv) begin
                        m_ovf[i] = 1;
                        if (MS[i] == 0) m_tmr[i] = 0;
                    end else begin
                        m_tmr[i] = old_t + 1;
                    end
                end
                if (rd && m_cnt[i] > 0) begin
                    for (int k = 0; k < L - 1; k++) m_fifo[i][k] = m_fifo[i][k+1];
                    m_cnt[i] = m_cnt[i] - 1;
                end
                if (lp) begin
                    if (m_cnt[i] < L) begin
                        m_fifo[i][m_cnt[i]] = old_t;
                        m_cnt[i] = m_cnt[i] + 1;
                    end else begin
                        m_drop[i] = 1;
                    end
                end
            end
            m_run[i] = m_run[i] ^ int'(tg);
        end
    endtask

    task automatic step(input bit tg, input bit cl, input bit lp, input bit rd);
        toggle = tg; clear = cl; lap = lp; lap_rd = rd;
        @(posedge clk);
        model_step(tg, cl, lp, rd);
        @(negedge clk);
        toggle = 1'b0; clear = 1'b0; lap = 1'b0; lap_rd = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (o_tmr[i] !== 16'd0 || o_run[i] !== 1'b0 || o_ovf[i] !== 1'b0 || o_val[i] !== 1'b0 ||
                o_cnt[i] !== 3'd0 || o_drop[i] !== 1'b0 || o_ld[i] !== 16'd0) begin
                failures++;
                $display("FAIL reset_state inst=%0d got tmr=%0d run=%b ovf=%b val=%b cnt=%0d drop=%b ld=%0d exp all 0",
                         i, o_tmr[i], o_run[i], o_ovf[i], o_val[i], o_cnt[i], o_drop[i], o_ld[i]);
            end
        end
    endtask

    task automatic test_start_stop();
        step(1, 0, 0, 0);
        for (int k = 0; k < 8; k++) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        checks++;
        if (o_tmr[0] !== 16'd3 || o_run[0] !== 1'b0) begin
            failures++;
            $display("FAIL start_stop got timer=%0d running=%b exp timer=3 running=0", o_tmr[0], o_run[0]);
        end
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        for (int k = 0; k < 5; k++) step(0, 0, 0, 0);
        checks++;
        if (o_tmr[0] !== 16'd3 || o_run[0] !== 1'b0) begin
            failures++;
            $display("FAIL stop_hold got timer=%0d running=%b exp timer=3 running=0", o_tmr[0], o_run[0]);
        end
        step(1, 0, 0, 0);
        checks++;
        if (o_tmr[0] !== 16'd3 || o_run[0] !== 1'b1) begin
            failures++;
            $display("FAIL resume_edge got timer=%0d running=%b exp timer=3 running=1", o_tmr[0], o_run[0]);
        end
        step(0, 0, 0, 0);
        checks++;
        if (o_tmr[0] !== 16'd4) begin
            failures++;
            $display("FAIL resume_partial got timer=%0d exp 4", o_tmr[0]);
        end
        step(1, 0, 0, 0);
    endtask

    task automatic test_overflow();
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            step(0, 0, 0, 0);
            if (k == 15) begin
                checks++;
                if (o_tmr[1] !== 16'd15 || o_ovf[1] !== 1'b0) begin
                    failures++;
                    $display("FAIL ovf_pre_wrap got timer=%0d ovf=%b exp timer=15 ovf=0", o_tmr[1], o_ovf[1]);
                end
            end
            if (k == 16) begin
                checks++;
                if (o_tmr[1] !== 16'd0 || o_ovf[1] !== 1'b1 || o_tmr[2] !== 16'd15 || o_ovf[2] !== 1'b1) begin
                    failures++;
                    $display("FAIL ovf_tick16 got wrap=%0d/%b sat=%0d/%b exp 0/1 15/1",
                             o_tmr[1], o_ovf[1], o_tmr[2], o_ovf[2]);
                end
            end
        end
        step(1, 0, 0, 0);
        checks++;
        if (o_tmr[1] !== 16'd1 || o_ovf[1] !== 1'b1 || o_run[1] !== 1'b0) begin
            failures++;
            $display("FAIL ovf_wrap17 got timer=%0d ovf=%b run=%b exp 1 1 0", o_tmr[1], o_ovf[1], o_run[1]);
        end
        checks++;
        if (o_tmr[2] !== 16'd15 || o_ovf[2] !== 1'b1) begin
            failures++;
            $display("FAIL ovf_sat17 got timer=%0d ovf=%b exp 15 1", o_tmr[2], o_ovf[2]);
        end
    endtask

    task automatic test_lap_fifo();
        int tgt [5] = '{2, 5, 7, 9, 11};
        int exp_rd [4] = '{2, 5, 7, 9};
        int guard;
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        for (int n = 0; n < 5; n++) begin
            guard = 0;
            while (m_tmr[1] != tgt[n] && guard < 40) begin
                step(0, 0, 0, 0);
                guard++;
            end
            checks++;
            if (guard >= 40 || o_tmr[1] !== 16'(tgt[n])) begin
                failures++;
                $display("FAIL lap_reach got timer=%0d exp %0d", o_tmr[1], tgt[n]);
            end
            step(0, 0, 1, 0);
            checks++;
            if (o_cnt[1] !== 3'(n < 4 ? n + 1 : 4) || o_drop[1] !== (n == 4)) begin
                failures++;
                $display("FAIL lap_push%0d got cnt=%0d drop=%b exp cnt=%0d drop=%0d",
                         n, o_cnt[1], o_drop[1], (n < 4 ? n + 1 : 4), (n == 4));
            end
        end
        step(1, 0, 0, 0);
        checks++;
        if (o_drop[1] !== 1'b0) begin
            failures++;
            $display("FAIL lap_drop_pulse got drop=%b exp 0", o_drop[1]);
        end
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (o_val[1] !== 1'b1 || o_ld[1] !== 16'(exp_rd[n])) begin
                failures++;
                $display("FAIL lap_read%0d got valid=%b data=%0d exp 1 %0d", n, o_val[1], o_ld[1], exp_rd[n]);
            end
            step(0, 0, 0, 1);
        end
        checks++;
        if (o_val[1] !== 1'b0 || o_cnt[1] !== 3'd0) begin
            failures++;
            $display("FAIL lap_empty got valid=%b cnt=%0d exp 0 0", o_val[1], o_cnt[1]);
        end
    endtask

    task automatic test_simultaneous();
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        for (int n = 0; n < 4; n++) step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        checks++;
        if (o_cnt[1] !== 3'd4 || o_ld[1] !== 16'd1 || o_drop[1] !== 1'b0) begin
            failures++;
            $display("FAIL full_lap_rd got cnt=%0d head=%0d drop=%b exp 4 1 0", o_cnt[1], o_ld[1], o_drop[1]);
        end
        step(1, 0, 0, 0);
        for (int n = 1; n <= 4; n++) begin
            checks++;
            if (o_ld[1] !== 16'(n)) begin
                failures++;
                $display("FAIL full_lap_rd_order got data=%0d exp %0d", o_ld[1], n);
            end
            step(0, 0, 0, 1);
        end
        step(0, 0, 1, 0);
        step(1, 1, 1, 0);
        checks++;
        if (o_tmr[1] !== 16'd0 || o_cnt[1] !== 3'd0 || o_val[1] !== 1'b0 || o_run[1] !== 1'b1) begin
            failures++;
            $display("FAIL clear_lap_toggle got timer=%0d cnt=%0d valid=%b run=%b exp 0 0 0 1",
                     o_tmr[1], o_cnt[1], o_val[1], o_run[1]);
        end
        step(1, 0, 0, 0);
    endtask

    task automatic test_async_reset();
        int guard = 0;
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        while (m_tmr[3] != 16'h1234 && guard < 6000) begin
            step(0, 0, 0, 0);
            guard++;
        end
        checks++;
        if (guard >= 6000 || o_tmr[3] !== 16'h1234 || o_cnt[3] !== 3'd2) begin
            failures++;
            $display("FAIL areset_setup got timer=%h cnt=%0d exp 1234 2", o_tmr[3], o_cnt[3]);
        end
        #2 reset = 1'b0;
        #1;
        test_reset();
        model_reset();
        reset = 1'b1;
        step(1, 0, 0, 0);
        checks++;
        if (o_tmr[3] !== 16'd0 || o_run[3] !== 1'b1) begin
            failures++;
            $display("FAIL areset_restart got timer=%0d run=%b exp 0 1", o_tmr[3], o_run[3]);
        end
        step(0, 0, 0, 0);
        checks++;
        if (o_tmr[3] !== 16'd1) begin
            failures++;
            $display("FAIL areset_count got timer=%0d exp 1", o_tmr[3]);
        end
    endtask

    task automatic test_random();
        bit tg, cl, lp, rd;
        int exp_ld;
        for (int c = 0; c < 600; c++) begin
            tg = ($urandom % 8) == 0;
            cl = ($urandom % 40) == 0;
            lp = ($urandom % 3) == 0;
            rd = ($urandom % 3) == 0;
            step(tg, cl, lp, rd);
            for (int i = 0; i < NI; i++) begin
                exp_ld = (m_cnt[i] > 0) ? m_fifo[i][0] : 0;
                checks++;
                if (o_tmr[i] !== 16'(m_tmr[i]) || o_run[i] !== 1'(m_run[i]) || o_ovf[i] !== 1'(m_ovf[i]) ||
                    o_cnt[i] !== 3'(m_cnt[i]) || o_val[i] !== (m_cnt[i] > 0) ||
                    o_drop[i] !== 1'(m_drop[i]) || o_ld[i] !== 16'(exp_ld)) begin
                    failures++;
                    $display("FAIL random c=%0d inst=%0d got tmr=%0d run=%b ovf=%b cnt=%0d drop=%b ld=%0d exp %0d %0d %0d %0d %0d %0d",
                             c, i, o_tmr[i], o_run[i], o_ovf[i], o_cnt[i], o_drop[i], o_ld[i],
                             m_tmr[i], m_run[i], m_ovf[i], m_cnt[i], m_drop[i], exp_ld);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b0; toggle = 1'b0; clear = 1'b0; lap = 1'b0; lap_rd = 1'b0;
        model_reset();
        #2;
        test_reset();
        @(negedge clk);
        reset = 1'b1;
        test_start_stop();
        test_overflow();
        test_lap_fifo();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1);
    end

endmodule
